// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl
//
// Successive-approximation search controller. It drives the probe operand
// of an external combinational magnitude comparator whose other operand is
// an unknown target, and recovers that target one bit per clock, MSB first.
// A final verify compare confirms the recovered value.
//
// Configuration macro: EARLY_EXIT_EN
//   defined   - an "equal" answer during SEARCH ends the search at once
//               (found=1, VERIFY skipped).
//   undefined - "equal" during SEARCH is treated like "less" (bit kept) and
//               latency is fixed at WIDTH+2 cycles from the start edge.
//
// Ports
//   clk     in   1      clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      search request, sampled only in IDLE
//   cmp_l   in   1      comparator: probe <  target
//   cmp_e   in   1      comparator: probe == target
//   cmp_g   in   1      comparator: probe >  target
//   probe   out  WIDTH  registered value presented to the comparator
//   busy    out  1      high in SEARCH and VERIFY
//   done    out  1      one-cycle completion pulse
//   found   out  1      final compare returned equal; held until next start
//   err     out  1      invalid comparator code seen; held until next start
//   result  out  WIDTH  recovered value; held until next start
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_l,
    input  logic             cmp_e,
    input  logic             cmp_g,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int KW = $clog2(WIDTH);
    localparam logic [KW-1:0]    K_MSB     = KW'(WIDTH - 1);
    localparam logic [KW-1:0]    K_ONE     = KW'(1);
    localparam logic [WIDTH-1:0] PROBE_MSB = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_VERIFY,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  probe_q, probe_d;
    logic [KW-1:0]     k_q, k_d;
    logic              found_q, found_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  result_q, result_d;

    logic              code_ok;
    logic              early_hit;

    // Exactly one of l/e/g must be asserted for a trustworthy answer.
    always_comb begin
        code_ok = 1'b0;
        case ({cmp_l, cmp_e, cmp_g})
            3'b100, 3'b010, 3'b001: code_ok = 1'b1;
            default:                code_ok = 1'b0;
        endcase
    end

`ifdef EARLY_EXIT_EN
    assign early_hit = cmp_e;
`else
    assign early_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        probe_d  = probe_q;
        k_d      = k_q;
        found_d  = found_q;
        err_d    = err_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    probe_d  = PROBE_MSB;
                    k_d      = K_MSB;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    state_d  = S_SEARCH;
                end
            end

            S_SEARCH: begin
                if (!code_ok) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = probe_q;
                    state_d  = S_DONE;
                end else if (early_hit) begin
                    found_d  = 1'b1;
                    result_d = probe_q;
                    state_d  = S_DONE;
                end else begin
                    // Trial bit k stays set unless the probe overshoots.
                    if (cmp_g) begin
                        probe_d[k_q] = 1'b0;
                    end
                    if (k_q != '0) begin
                        probe_d[k_q - K_ONE] = 1'b1;
                        k_d                  = k_q - K_ONE;
                    end else begin
                        state_d = S_VERIFY;
                    end
                end
            end

            S_VERIFY: begin
                if (!code_ok) begin
                    err_d   = 1'b1;
                    found_d = 1'b0;
                end else begin
                    found_d = cmp_e;
                end
                result_d = probe_q;
                state_d  = S_DONE;
            end

            S_DONE: begin
                // start is deliberately not looked at here.
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            probe_q  <= '0;
            k_q      <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            probe_q  <= probe_d;
            k_q      <= k_d;
            found_q  <= found_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign probe  = probe_q;
    assign busy   = (state_q == S_SEARCH) || (state_q == S_VERIFY);
    assign done   = (state_q == S_DONE);
    assign found  = found_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
module tb_sar_search_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         cmp_l, cmp_e, cmp_g;
    logic [W-1:0] probe;
    logic         busy, done, found, err;
    logic [W-1:0] result;

    // Ideal comparator with an override that forces an invalid l=g=1 code.
    logic [W-1:0] tgt;
    logic         bad;

    always_comb begin
        cmp_l = bad ? 1'b1 : (probe < tgt);
        cmp_e = bad ? 1'b0 : (probe == tgt);
        cmp_g = bad ? 1'b1 : (probe > tgt);
    end

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_l  (cmp_l),
        .cmp_e  (cmp_e),
        .cmp_g  (cmp_g),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .err    (err),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int result;
        int found;
        int err;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   probe_exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    int start_cyc = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Reference behaviour: replays the search against the comparator stimulus
    // the driver will apply, queueing the probe seen each busy cycle and the
    // final outcome. Trial i lives in cycle i+1 (cycle 1 follows the start edge).
    task automatic sb_push(input int t_first, input int t_rest, input int bad_trial);
        logic [W-1:0] p;
        int   k;
        int   c;
        int   tg;
        bit   early;
        exp_t e;
`ifdef EARLY_EXIT_EN
        early = 1'b1;
`else
        early = 1'b0;
`endif
        p = 4'b1000;
        k = W - 1;
        c = 1;
        for (int i = 0; i < W; i++) begin
            tg = (i == 0) ? t_first : t_rest;
            probe_exp_q.push_back(int'(p));
            if (i == bad_trial) begin
                e = '{int'(p), 0, 1, c + 1};
                exp_q.push_back(e);
                return;
            end
            if (early && int'(p) == tg) begin
                e = '{int'(p), 1, 0, c + 1};
                exp_q.push_back(e);
                return;
            end
            if (int'(p) > tg) p[k] = 1'b0;
            if (k > 0) p[k-1] = 1'b1;
            k--;
            c++;
        end
        probe_exp_q.push_back(int'(p));
        if (bad_trial == W) e = '{int'(p), 0, 1, c + 1};
        else                e = '{int'(p), (int'(p) == t_rest) ? 1 : 0, 0, c + 1};
        exp_q.push_back(e);
    endtask

    // Monitor: compares probes while busy and the outcome on the done pulse.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (busy) begin
                if (probe_exp_q.size() == 0) chk("probe_q_underflow", 1, 0);
                else chk("probe", int'(probe), probe_exp_q.pop_front());
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("txn: result=%0d found=%0d err=%0d cycle=%0d (exp %0d/%0d/%0d/%0d)",
                             result, found, err, cyc_cnt - start_cyc,
                             e.result, e.found, e.err, e.lat);
                    chk("result", int'(result), e.result);
                    chk("found", int'(found), e.found);
                    chk("err", int'(err), e.err);
                    chk("latency", cyc_cnt - start_cyc, e.lat);
                    chk("busy_in_done", int'(busy), 0);
                end
            end
        end
    end

    task automatic run(input int t_first, input int t_rest, input int bad_trial,
                       input bit stray);
        int  c;
        bit  seen;
        sb_push(t_first, t_rest, bad_trial);
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc_cnt;
        tgt       = 4'(t_first);
        bad       = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 1'b0;
        for (c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            tgt   = 4'((c == 1) ? t_first : t_rest);
            bad   = ((c - 1) == bad_trial);
            start = stray && (c == 2);
            if (done) begin
                seen = 1'b1;
                bad  = 1'b0;
                if (stray) begin
                    start = 1'b1;
                    @(posedge clk);
                    #1 start = 1'b0;
                end
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("scoreboard_empty", exp_q.size() + probe_exp_q.size(), 0);
    endtask

    initial begin
        int dcount;
        rst_n = 1'b0;
        start = 1'b0;
        tgt   = '0;
        bad   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_probe", int'(probe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_result", int'(result), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        run(11, 11, -1, 1'b0);
        run(0, 0, -1, 1'b0);
        run(15, 15, -1, 1'b0);
        run(11, 11, 1, 1'b0);        // invalid code on the 2nd trial
        run(6, 6, W, 1'b0);          // invalid code in the verify cycle
        run(5, 9, -1, 1'b1);         // target moves; stray starts ignored
        for (int i = 0; i < 4; i++) begin
            int t;
            t = int'($urandom_range(0, 15));
            run(t, t, -1, 1'b0);
        end

        // Reset in the 3rd SEARCH cycle aborts with no done pulse.
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        tgt   = 4'd11;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_probe", int'(probe), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_found", int'(found), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_result", int'(result), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        dcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        mon_en = 1'b1;
        run(11, 11, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
